serial_loader_5bit: RTL

SERIAL_LOADER_5BIT -- requirements
Module: serial_loader_5bit

---
 rtl/serial_loader_5bit_pkg.sv | 17 +
 rtl/serial_loader_5bit_shift_in.sv | 22 ++
 rtl/serial_loader_5bit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_loader_5bit_pkg.sv
// Shared definitions for the 5-bit serial loader.
// This file holds the state encoding, the word width and the bit-counter width.
package serial_loader_5bit_pkg;

  localparam int WORD_W = 5;
  localparam int CNT_W  = 3;

  // Counter value of the fifth accepted data bit (counter runs 0..4).
  localparam logic [CNT_W-1:0] LAST_BIT = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/serial_loader_5bit_shift_in.sv
// Serial-in, parallel-out shift register for the loader.
// New bits enter at the LSB, so the first bit received ends up as the MSB.
module shift_in_5bit
  import serial_loader_5bit_pkg::*;
(
  input  logic              Clock,
  input  logic              Clear,
  input  logic              en,
  input  logic              din,
  output logic [WORD_W-1:0] q
);

  // Clear wins over shifting; otherwise shift one bit in per enabled cycle.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WORD_W-2:0], din};
    end
  end

endmodule

// File: rtl/serial_loader_5bit.sv
// Serial frame loader. It receives 5 data bits, MSB first, followed by one
// parity bit. When the parity check passes it presents the assembled word
// with a one-cycle Load pulse. A frame can be restarted with Start, which
// raises Abort, and it can be dropped silently with Clear.
module serial_loader_5bit
  import serial_loader_5bit_pkg::*;
#(
  parameter bit ODD_PARITY = 1'b1
)
(
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Start,
  input  logic              serIn,
  input  logic              serValid,
  output logic [WORD_W-1:0] outData,
  output logic              Load,
  output logic              Busy,
  output logic              ParityErr,
  output logic              Abort
);

  state_t            stateReg, stateNext;
  logic [CNT_W-1:0]  cntReg, cntNext;
  logic [WORD_W-1:0] outReg, outNext;
  logic [WORD_W-1:0] shiftQ;
  logic              loadReg, loadNext;
  logic              errReg, errNext;
  logic              abortReg, abortNext;
  logic              shiftEn;
  logic              shiftClr;

  // Any Start, in any state, begins a fresh frame with an empty shift register.
  assign shiftClr = Clear | Start;

  shift_in_5bit u_shift (
    .Clock (Clock),
    .Clear (shiftClr),
    .en    (shiftEn),
    .din   (serIn),
    .q     (shiftQ)
  );

  // Next state, counter, output word and pulse decode. Start takes priority over serValid.
  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    outNext   = outReg;
    loadNext  = 1'b0;
    errNext   = 1'b0;
    abortNext = 1'b0;
    shiftEn   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (Start) begin
          stateNext = SHIFT;
          cntNext   = '0;
        end
      end
      SHIFT: begin
        if (Start) begin
          abortNext = 1'b1;
          cntNext   = '0;
        end else if (serValid) begin
          shiftEn = 1'b1;
          if (cntReg == LAST_BIT) begin
            stateNext = PARITY;
          end else begin
            cntNext = cntReg + 3'd1;
          end
        end
      end
      PARITY: begin
        if (Start) begin
          abortNext = 1'b1;
          stateNext = SHIFT;
          cntNext   = '0;
        end else if (serValid) begin
          stateNext = IDLE;
          cntNext   = '0;
          if ((^{shiftQ, serIn}) == ODD_PARITY) begin
            outNext  = shiftQ;
            loadNext = 1'b1;
          end else begin
            errNext = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  // State and registered outputs. Clear overrides every other input.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      stateReg <= IDLE;
      cntReg   <= '0;
      outReg   <= '0;
      loadReg  <= 1'b0;
      errReg   <= 1'b0;
      abortReg <= 1'b0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      outReg   <= outNext;
      loadReg  <= loadNext;
      errReg   <= errNext;
      abortReg <= abortNext;
    end
  end

  assign outData   = outReg;
  assign Load      = loadReg;
  assign ParityErr = errReg;
  assign Abort     = abortReg;
  assign Busy      = (stateReg != IDLE);

endmodule
